// File: rtl/com_pkg.sv
// Shared constants and types for the colour center-of-mass tracker.
package com_pkg;

    localparam int COORD_W  = 10;
    localparam int MASS_W   = 26;
    localparam int FRAC_W   = 4;
    localparam int ACC_W    = COORD_W + FRAC_W;
    localparam int CNT_W    = 4;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        SEARCH,
        TRACK,
        COAST
    } state_t;

    // Per-frame command from the tracker FSM to each axis filter.
    typedef enum logic [1:0] {
        AXIS_HOLD,
        AXIS_LOAD,
        AXIS_UPDATE,
        AXIS_CLEAR
    } axis_op_t;

endpackage

// File: rtl/com_axis_filter.sv
// One axis of the position filter: 10.4 fixed-point IIR accumulator, jump gate
// against the current position, and the signed per-frame position delta.
module com_axis_filter
    import com_pkg::*;
#(
    parameter int ALPHA_SHIFT = 2,
    parameter int JUMP_MAX    = 64,
    parameter int RESET_POS   = 320
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] center,
    input  axis_op_t           op,
    output logic               near,
    output logic [COORD_W-1:0] pos,
    output logic [COORD_W:0]   delta
);

    localparam logic [ACC_W-1:0] ACC_RESET = ACC_W'(RESET_POS * (2 ** FRAC_W));

    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        acc_filt;
    logic signed [ACC_W:0]   diff;
    logic signed [ACC_W:0]   step;
    logic signed [COORD_W:0] offset;
    logic [COORD_W:0]        offset_mag;

    assign pos = acc[ACC_W-1:FRAC_W];

    // NOTE: every combinational output gets a value before any branch, so no latch is inferred.
    always_comb begin
        diff       = $signed({1'b0, center, {FRAC_W{1'b0}}}) - $signed({1'b0, acc});
        step       = diff >>> ALPHA_SHIFT;
        acc_filt   = acc + step[ACC_W-1:0];
        offset     = $signed({1'b0, center}) - $signed({1'b0, pos});
        offset_mag = offset[COORD_W] ? COORD_W'(0) - offset : offset;
        near       = (offset_mag <= (COORD_W + 1)'(JUMP_MAX));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= ACC_RESET;
            delta <= '0;
        end else begin
            case (op)
                AXIS_LOAD: begin
                    acc   <= {center, {FRAC_W{1'b0}}};
                    delta <= '0;
                end
                AXIS_UPDATE: begin
                    acc   <= acc_filt;
                    delta <= {1'b0, acc_filt[ACC_W-1:FRAC_W]} - {1'b0, pos};
                end
                AXIS_CLEAR: delta <= '0;
                AXIS_HOLD:  ;
                default:    ;
            endcase
        end
    end

endmodule

// File: rtl/com_tracker.sv
// Per-frame target tracker: qualifies each center-of-mass result, runs the
// SEARCH/TRACK/COAST state machine and drives the two axis filters.
module com_tracker
    import com_pkg::*;
#(
    parameter logic [25:0] MASS_MIN    = 26'd2048,
    parameter int          ACQ_FRAMES  = 3,
    parameter int          LOST_FRAMES = 8,
    parameter int          ALPHA_SHIFT = 2,
    parameter int          JUMP_MAX    = 64,
    parameter int          X_RESET     = 320,
    parameter int          Y_RESET     = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_strobe,
    input  logic [9:0]  x_center,
    input  logic [9:0]  y_center,
    input  logic [25:0] mass,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic [10:0] dx,
    output logic [10:0] dy,
    output logic        locked,
    output logic        pos_valid,
    output logic        overrun
);

    logic [COORD_W-1:0] x_cap;
    logic [COORD_W-1:0] y_cap;
    logic [MASS_W-1:0]  mass_cap;
    logic               stage1;
    logic               stage2;
    logic               busy;
    logic               detect;
    logic               near_x;
    logic               near_y;
    logic               detect_q;
    logic               near_q;
    logic               hit;

    state_t             state, state_next;
    logic [CNT_W-1:0]   hit_cnt, hit_next, hit_inc;
    logic [CNT_W-1:0]   miss_cnt, miss_next, miss_inc;
    axis_op_t           axis_op;

    assign busy   = stage1 | stage2;
    assign detect = (mass_cap >= MASS_MIN)
                 && (x_cap < COORD_W'(SCREEN_W))
                 && (y_cap < COORD_W'(SCREEN_H));
    assign hit    = detect_q & near_q;
    assign locked = (state != SEARCH);

    // Strobe pipeline: capture, register qualification flags, then commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_cap     <= '0;
            y_cap     <= '0;
            mass_cap  <= '0;
            stage1    <= 1'b0;
            stage2    <= 1'b0;
            detect_q  <= 1'b0;
            near_q    <= 1'b0;
            pos_valid <= 1'b0;
            overrun   <= 1'b0;
            state     <= SEARCH;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            stage1    <= frame_strobe & ~busy;
            stage2    <= stage1;
            pos_valid <= stage2;
            if (frame_strobe && !busy) begin
                x_cap    <= x_center;
                y_cap    <= y_center;
                mass_cap <= mass;
            end
            if (frame_strobe && busy)
                overrun <= 1'b1;
            if (stage1) begin
                detect_q <= detect;
                near_q   <= near_x & near_y;
            end
            state    <= state_next;
            hit_cnt  <= hit_next;
            miss_cnt <= miss_next;
        end
    end

    always_comb begin
        state_next = state;
        hit_next   = hit_cnt;
        miss_next  = miss_cnt;
        axis_op    = AXIS_HOLD;
        hit_inc    = hit_cnt + 1'b1;
        miss_inc   = miss_cnt + 1'b1;

        if (stage2) begin
            case (state)
                SEARCH: begin
                    axis_op = AXIS_CLEAR;
                    if (!detect_q) begin
                        hit_next = '0;
                    end else if (hit_inc >= CNT_W'(ACQ_FRAMES)) begin
                        state_next = TRACK;
                        hit_next   = '0;
                        miss_next  = '0;
                        axis_op    = AXIS_LOAD;
                    end else begin
                        hit_next = hit_inc;
                    end
                end
                TRACK, COAST: begin
                    if (hit) begin
                        state_next = TRACK;
                        miss_next  = '0;
                        axis_op    = AXIS_UPDATE;
                    end else begin
                        // miss_cnt is zero in TRACK, so the first miss counts as one.
                        axis_op = AXIS_CLEAR;
                        if (miss_inc >= CNT_W'(LOST_FRAMES)) begin
                            state_next = SEARCH;
                            miss_next  = '0;
                            hit_next   = '0;
                        end else begin
                            state_next = COAST;
                            miss_next  = miss_inc;
                        end
                    end
                end
                default: begin
                    state_next = SEARCH;
                    hit_next   = '0;
                    miss_next  = '0;
                end
            endcase
        end
    end

    com_axis_filter #(
        .ALPHA_SHIFT(ALPHA_SHIFT),
        .JUMP_MAX   (JUMP_MAX),
        .RESET_POS  (X_RESET)
    ) u_filter_x (
        .clk   (clk),
        .reset (reset),
        .center(x_cap),
        .op    (axis_op),
        .near  (near_x),
        .pos   (x_pos),
        .delta (dx)
    );

    com_axis_filter #(
        .ALPHA_SHIFT(ALPHA_SHIFT),
        .JUMP_MAX   (JUMP_MAX),
        .RESET_POS  (Y_RESET)
    ) u_filter_y (
        .clk   (clk),
        .reset (reset),
        .center(y_cap),
        .op    (axis_op),
        .near  (near_y),
        .pos   (y_pos),
        .delta (dy)
    );

endmodule

// File: tb/tb_com_tracker.sv
// Self-checking bench for com_tracker: hand-computed frame table, multi-cycle
// corner sequences, and randomized frames against a per-frame reference model.
module tb_com_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_strobe;
    logic [9:0]  x_center;
    logic [9:0]  y_center;
    logic [25:0] mass;
    logic [9:0]  x_pos;
    logic [9:0]  y_pos;
    logic [10:0] dx;
    logic [10:0] dy;
    logic        locked;
    logic        pos_valid;
    logic        overrun;

    always #5 clk = ~clk;

    com_tracker dut (
        .clk         (clk),
        .reset       (reset),
        .frame_strobe(frame_strobe),
        .x_center    (x_center),
        .y_center    (y_center),
        .mass        (mass),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .dx          (dx),
        .dy          (dy),
        .locked      (locked),
        .pos_valid   (pos_valid),
        .overrun     (overrun)
    );

    typedef struct {
        int x;
        int y;
        int m;
        int exp_x;
        int exp_y;
        int exp_dx;
        int exp_dy;
        int exp_locked;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: accumulators in 1/16 pixel, consecutive hit/miss runs.
    int  m_acc_x, m_acc_y, m_hits, m_misses, m_dx, m_dy;
    bit  m_locked;

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        frame_strobe = 1'b0;
        x_center     = '0;
        y_center     = '0;
        mass         = '0;
        tick();
        tick();
        reset = 1'b0;
        m_acc_x  = 320 * 16;
        m_acc_y  = 240 * 16;
        m_hits   = 0;
        m_misses = 0;
        m_locked = 1'b0;
        m_dx     = 0;
        m_dy     = 0;
    endtask

    task automatic strobe(input int x, input int y, input int m);
        frame_strobe = 1'b1;
        x_center     = 10'(x);
        y_center     = 10'(y);
        mass         = 26'(m);
        tick();
        frame_strobe = 1'b0;
    endtask

    // Strobe, then confirm pos_valid is low at T+2 and high after the T+2 edge.
    task automatic send_frame(input int x, input int y, input int m, input string tag);
        strobe(x, y, m);
        tick();
        check({tag, " pos_valid early"}, int'(pos_valid), 0);
        tick();
        check({tag, " pos_valid"}, int'(pos_valid), 1);
    endtask

    task automatic model_frame(input int x, input int y, input int m);
        bit det, near;
        int nx, ny;
        det  = (m >= 2048) && (x < 640) && (y < 480);
        near = ((x - (m_acc_x / 16)) <= 64) && (((m_acc_x / 16) - x) <= 64)
            && ((y - (m_acc_y / 16)) <= 64) && (((m_acc_y / 16) - y) <= 64);
        m_dx = 0;
        m_dy = 0;
        if (!m_locked) begin
            m_hits = det ? m_hits + 1 : 0;
            if (m_hits == 3) begin
                m_locked = 1'b1;
                m_hits   = 0;
                m_misses = 0;
                m_acc_x  = x * 16;
                m_acc_y  = y * 16;
            end
        end else if (det && near) begin
            nx       = m_acc_x + ((x * 16 - m_acc_x) >>> 2);
            ny       = m_acc_y + ((y * 16 - m_acc_y) >>> 2);
            m_dx     = nx / 16 - m_acc_x / 16;
            m_dy     = ny / 16 - m_acc_y / 16;
            m_acc_x  = nx;
            m_acc_y  = ny;
            m_misses = 0;
        end else begin
            m_misses++;
            if (m_misses == 8) begin
                m_locked = 1'b0;
                m_misses = 0;
                m_hits   = 0;
            end
        end
    endtask

    initial begin
        vec_t vecs[$];
        int   px, py, pm, gap;

        do_reset();
        check("reset x_pos", int'(x_pos), 320);
        check("reset y_pos", int'(y_pos), 240);
        check("reset dx", int'($signed(dx)), 0);
        check("reset dy", int'($signed(dy)), 0);
        check("reset locked", int'(locked), 0);
        check("reset pos_valid", int'(pos_valid), 0);
        check("reset overrun", int'(overrun), 0);

        // x, y, mass -> x_pos, y_pos, dx, dy, locked
        vecs.push_back('{100,  50,  2047, 320, 240,   0,  0, 0}); // mass just below threshold
        vecs.push_back('{100,  50,  2048, 320, 240,   0,  0, 0});
        vecs.push_back('{100,  50,  5000, 320, 240,   0,  0, 0});
        vecs.push_back('{100,  50,  5000, 100,  50,   0,  0, 1}); // third detect locks
        vecs.push_back('{200,  50,  5000, 100,  50,   0,  0, 1}); // jump -> COAST
        vecs.push_back('{120,  50,  5000, 105,  50,   5,  0, 1});
        vecs.push_back('{140,  50,  5000, 113,  50,   8,  0, 1});
        vecs.push_back('{100,  50,  5000, 110,  50,  -3,  0, 1});
        vecs.push_back('{174,  50,  5000, 126,  50,  16,  0, 1}); // |diff| = 64 accepted
        vecs.push_back('{191,  50,  5000, 126,  50,   0,  0, 1}); // |diff| = 65 rejected
        vecs.push_back('{700,  50, 90000, 126,  50,   0,  0, 1}); // off-screen x
        vecs.push_back('{126, 480, 90000, 126,  50,   0,  0, 1}); // off-screen y
        vecs.push_back('{126, 100,  5000, 126,  62,   0, 12, 1});
        for (int i = 0; i < 7; i++)
            vecs.push_back('{126, 62, 100, 126, 62, 0, 0, 1});
        vecs.push_back('{126,  62,   100, 126,  62,   0,  0, 0}); // 8th miss drops lock
        vecs.push_back('{130,  60,  5000, 126,  62,   0,  0, 0});
        vecs.push_back('{130,  60,  5000, 126,  62,   0,  0, 0});
        vecs.push_back('{130,  60,  5000, 130,  60,   0,  0, 1});

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            send_frame(vecs[i].x, vecs[i].y, vecs[i].m, tag);
            check({tag, " x_pos"}, int'(x_pos), vecs[i].exp_x);
            check({tag, " y_pos"}, int'(y_pos), vecs[i].exp_y);
            check({tag, " dx"}, int'($signed(dx)), vecs[i].exp_dx);
            check({tag, " dy"}, int'($signed(dy)), vecs[i].exp_dy);
            check({tag, " locked"}, int'(locked), vecs[i].exp_locked);
            tick();
            check({tag, " pos_valid width"}, int'(pos_valid), 0);
        end
        check("table overrun", int'(overrun), 0);

        // Second strobe at T+1 is dropped and sets sticky overrun.
        do_reset();
        strobe(100, 50, 5000);
        strobe(300, 300, 5000);
        tick();
        check("ovr pos_valid", int'(pos_valid), 1);
        check("ovr flag", int'(overrun), 1);
        send_frame(100, 50, 5000, "ovr T+3");
        check("ovr second locked", int'(locked), 0);
        send_frame(100, 50, 5000, "ovr third");
        check("ovr third locked", int'(locked), 1);
        check("ovr third x_pos", int'(x_pos), 100);
        check("ovr sticky", int'(overrun), 1);

        // Strobe at T+2 is also inside the busy window.
        do_reset();
        strobe(100, 50, 5000);
        tick();
        strobe(100, 50, 5000);
        check("ovr T+2 pos_valid", int'(pos_valid), 1);
        check("ovr T+2 flag", int'(overrun), 1);
        tick();
        tick();
        check("ovr T+2 ignored", int'(pos_valid), 0);

        // Reset at T+1 discards the in-flight frame.
        do_reset();
        for (int i = 0; i < 3; i++) send_frame(100, 50, 5000, "rst acq");
        check("rst acq locked", int'(locked), 1);
        strobe(140, 50, 5000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst pos_valid T+2", int'(pos_valid), 0);
        tick();
        check("rst pos_valid T+3", int'(pos_valid), 0);
        check("rst x_pos", int'(x_pos), 320);
        check("rst y_pos", int'(y_pos), 240);
        check("rst dx", int'($signed(dx)), 0);
        check("rst locked", int'(locked), 0);

        // Randomized frames, mostly near the model's position so lock is exercised.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            string tag;
            tag = $sformatf("rnd%0d", i);
            if ($urandom_range(0, 9) < 7) begin
                px = m_acc_x / 16 + $urandom_range(0, 160) - 80;
                py = m_acc_y / 16 + $urandom_range(0, 160) - 80;
                if (px < 0) px = 0;
                if (py < 0) py = 0;
            end else begin
                px = $urandom_range(0, 700);
                py = $urandom_range(0, 520);
            end
            pm = ($urandom_range(0, 9) < 8) ? 2048 + $urandom_range(0, 100000)
                                            : $urandom_range(0, 2100);
            send_frame(px, py, pm, tag);
            model_frame(px, py, pm);
            check({tag, " x_pos"}, int'(x_pos), m_acc_x / 16);
            check({tag, " y_pos"}, int'(y_pos), m_acc_y / 16);
            check({tag, " dx"}, int'($signed(dx)), m_dx);
            check({tag, " dy"}, int'($signed(dy)), m_dy);
            check({tag, " locked"}, int'(locked), int'(m_locked));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
        end
        check("rnd overrun", int'(overrun), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/com_tracker.md
Name: com_tracker

Overview:
- Downstream consumer of the per-frame colour center-of-mass results (x/y center plus total colour mass).
- Qualifies each frame's measurement and acquires/tracks/coasts a target with a small state machine.
- Smooths position with a first-order IIR filter and produces per-frame displacement for the motion-control logic.
- Runs once per frame (~30 Hz) on a one-cycle frame strobe; everything else is idle time.

Parameters:
- MASS_MIN, 26'd2048, minimum colour mass for a frame to count as a detection.
- ACQ_FRAMES, 3, consecutive detections required to lock (1..15).
- LOST_FRAMES, 8, consecutive misses while locked before dropping lock (1..15).
- ALPHA_SHIFT, 2, IIR gain = 2^-ALPHA_SHIFT (0..4; 0 = no smoothing).
- JUMP_MAX, 64, max per-axis |center - x_pos/y_pos| accepted while locked, in pixels.
- X_RESET, 320, reset value of x_pos.
- Y_RESET, 240, reset value of y_pos.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- frame_strobe  in  1  one-cycle pulse when x_center/y_center/mass hold a new frame result.
- x_center  in  10  frame center x, pixels.
- y_center  in  10  frame center y, pixels.
- mass  in  26  frame colour total (divisor of the center computation).
- x_pos  out  10  filtered x position.
- y_pos  out  10  filtered y position.
- dx  out  11  signed x_pos change from the previous frame update.
- dy  out  11  signed y_pos change from the previous frame update.
- locked  out  1  high in TRACK or COAST.
- pos_valid  out  1  one-cycle pulse when outputs update.
- overrun  out  1  sticky; a frame_strobe arrived while busy.

Behaviour:
- Reset values: x_pos=X_RESET, y_pos=Y_RESET, dx=dy=0, locked=0, pos_valid=0, overrun=0, state=SEARCH, hit_cnt=miss_cnt=0, accumulators={X_RESET,4'b0},{Y_RESET,4'b0}.
- Reset mid-operation returns everything to reset values on the next edge; an in-flight frame is discarded.
- Pipeline (strobe in cycle T):
  - T: inputs captured.
  - T+1: flags registered. detect = (mass >= MASS_MIN) && x<640 && y<480. near = |x_c - x_pos| <= JUMP_MAX && |y_c - y_pos| <= JUMP_MAX.
  - T+2: state, counters and outputs update; pos_valid=1 for exactly this cycle.
- busy spans T+1..T+2. A frame_strobe while busy is ignored and sets overrun; overrun clears only on reset.
- Filter, per axis, 14-bit unsigned acc in 10.4 fixed point:
  - acc <= acc + ((c<<4) - acc) >>> ALPHA_SHIFT, with the difference signed 15-bit and an arithmetic shift.
  - pos = acc[13:4] (truncate).
  - dx = new pos - old pos, sign-extended to 11 bits.
- FSM, evaluated at T+2:
  - SEARCH: detect → hit_cnt++. On reaching ACQ_FRAMES: go to TRACK, load acc = c<<4 directly (no filtering), dx=dy=0, hit_cnt=0. !detect → hit_cnt=0. Positions hold. locked=0.
  - TRACK: hit = detect && near → filter update, dx/dy from update. Otherwise → COAST, miss_cnt=1, positions hold, dx=dy=0.
  - COAST: hit → TRACK, filter update from the held acc, miss_cnt=0. Miss → miss_cnt++. At LOST_FRAMES → SEARCH, locked=0, positions hold, hit_cnt=0. dx=dy=0 on a miss.
  - LOST_FRAMES=1: the first miss in TRACK goes straight to SEARCH.
- A detect that fails near counts as a miss in TRACK/COAST. In SEARCH near is ignored.
- No saturation is needed: acc stays within [0, 639<<4] because inputs are range-checked.

Decomposition:
- Package com_pkg:
  - COORD_W=10, MASS_W=26, FRAC_W=4, SCREEN_W=640, SCREEN_H=480.
  - State enum {SEARCH, TRACK, COAST}.
- Sub-module com_axis_filter, instantiated twice (x, y). It holds acc, computes near-per-axis, the filter update, load, and the signed delta. com_tracker holds the FSM, counters and strobe pipeline.

Test Plan:
- Reset, then 3 strobes at (100,50), mass 5000 → pos_valid at T+2 each. locked rises on the 3rd. x_pos=100, y_pos=50, dx=dy=0.
- Locked at (100,50), ALPHA_SHIFT=2, strobe (140,50) → x_pos=110, dx=+10, y_pos=50, dy=0. Next strobe (140,50) → x_pos=117, dx=+7.
- Locked at x_pos=100, strobe (200,50) with valid mass → COAST, locked=1, x_pos=100, dx=0. Then (120,50) → TRACK, x_pos=105.
- Locked, 8 strobes with mass=100 → locked drops exactly on the 8th pos_valid; positions unchanged. A 9th strobe with good mass restarts the count (hit_cnt=1, locked=0).
- Second strobe at T+1 → ignored, overrun=1 and stays 1. A strobe at T+3 is processed normally.
- Reset asserted at T+1 of a strobe → no pos_valid at T+2, all outputs at reset values. Also: x_center=700 with large mass → treated as a miss.
